timepulse_sequencer: RTL and testbench

- Parametrised successor to the fixed ten-pulse sequence generator. Produces a one-hot train of NUM_PULSES timing pulses that form one memory cycle time (MCT).
- Adds start/stop control, stall, single-step mode, an end-of-MCT strobe and a pulse index output.
- Sits at the top of the simulator's control path. Drives every timing-pulse consumer: register gating, memory strobes and control-pulse decode.

---
 rtl/tp_pkg.sv | 15 +
 rtl/tp_ring_counter.sv | 31 +++
 rtl/timepulse_sequencer.sv | 116 +++++++++++
 tb/tb_timepulse_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tp_pkg.sv
// Shared types and helpers for the timing-pulse sequencer.
package tp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TP_MAX = 32;

    function automatic logic [TP_MAX-1:0] onehot(input int unsigned idx);
        return TP_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/tp_ring_counter.sv
// Pulse index register with a registered one-hot decode; clr/rst blank the pulse, load0 restarts at TP1.
module tp_ring_counter
    import tp_pkg::*;
#(
    parameter int NUM_PULSES = 12,
    parameter int IDX_W      = $clog2(NUM_PULSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load0,
    input  logic                  inc,
    input  logic                  clr,
    output logic [IDX_W-1:0]      index,
    output logic [NUM_PULSES-1:0] onehot
);

    // The local port shadows the package helper, so the helper is called by its scoped name.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            index  <= '0;
            onehot <= '0;
        end else if (load0) begin
            index  <= '0;
            onehot <= NUM_PULSES'(tp_pkg::onehot(32'd0));
        end else if (inc) begin
            index  <= index + IDX_W'(1);
            onehot <= NUM_PULSES'(tp_pkg::onehot(32'(index) + 32'd1));
        end
    end

endmodule

// File: rtl/timepulse_sequencer.sv
// One-hot timing-pulse train generator (one MCT = NUM_PULSES pulses) with run/stall/step control.
// Optional MCT counter enabled by defining MCT_COUNTER_EN.
module timepulse_sequencer
    import tp_pkg::*;
#(
    parameter int  NUM_PULSES = 12,
    parameter int  CNT_W      = 16,
    localparam int IDX_W      = $clog2(NUM_PULSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  stall,
    input  logic                  step_mode,
    input  logic                  step,
    output logic [NUM_PULSES-1:0] tp,
    output logic [IDX_W-1:0]      tp_index,
    output logic                  busy,
    output logic                  mct_done,
    output logic [CNT_W-1:0]      mct_count
);

    state_t state_q, state_d;
    logic   load0, inc, clr, done_d;
    logic   done_q, busy_q;
    logic   advance, last;

    logic [IDX_W-1:0]      idx;
    logic [NUM_PULSES-1:0] oh;

    tp_ring_counter #(
        .NUM_PULSES (NUM_PULSES),
        .IDX_W      (IDX_W)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .load0  (load0),
        .inc    (inc),
        .clr    (clr),
        .index  (idx),
        .onehot (oh)
    );

    // A step coincident with stall is dropped, not remembered.
    assign advance = !stall && (!step_mode || step);
    assign last    = (idx == IDX_W'(NUM_PULSES - 1));

    always_comb begin
        state_d = state_q;
        load0   = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && advance) begin
                    state_d = RUN;
                    load0   = 1'b1;
                end
            end
            RUN: begin
                if (advance) begin
                    if (!last) begin
                        inc = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (run) begin
                            load0 = 1'b1;
                        end else begin
                            clr     = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            busy_q  <= (state_d == RUN);
        end
    end

    assign tp       = oh;
    assign tp_index = idx;
    assign busy     = busy_q;
    assign mct_done = done_q;

`ifdef MCT_COUNTER_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (done_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign mct_count = cnt_q;
`else
    assign mct_count = '0;
`endif

endmodule

// File: tb/tb_timepulse_sequencer.sv
// Randomized and directed bench for timepulse_sequencer against a pulse-position reference model.
module tb_timepulse_sequencer;

    localparam int NP = 12;
    localparam int CW = 4;
    localparam int IW = $clog2(NP);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          stall = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic [NP-1:0] tp;
    logic [IW-1:0] tp_index;
    logic          busy;
    logic          mct_done;
    logic [CW-1:0] mct_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: whether a pulse train is active, which pulse is lit,
    // whether an MCT just finished, and how many have finished.
    bit m_active = 0;
    int m_pos    = 0;
    bit m_done   = 0;
    int m_cnt    = 0;

    timepulse_sequencer #(
        .NUM_PULSES (NP),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .stall     (stall),
        .step_mode (step_mode),
        .step      (step),
        .tp        (tp),
        .tp_index  (tp_index),
        .busy      (busy),
        .mct_done  (mct_done),
        .mct_count (mct_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        bit adv;
        if (rst) begin
            m_active = 0;
            m_pos    = 0;
            m_done   = 0;
            m_cnt    = 0;
            return;
        end
        adv    = !stall && (!step_mode || step);
        m_done = 0;
        if (!m_active) begin
            if (run && adv) begin
                m_active = 1;
                m_pos    = 0;
            end
        end else if (adv) begin
            if (m_pos < NP - 1) begin
                m_pos++;
            end else begin
                m_done = 1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
                m_pos  = 0;
                if (!run) m_active = 0;
            end
        end
    endfunction

    task automatic check_all();
        logic [31:0] exp_tp;
        int          exp_cnt;
        exp_tp = m_active ? (32'd1 << m_pos) : 32'd0;
`ifdef MCT_COUNTER_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("tp", 32'(tp), exp_tp);
        chk("tp_index", 32'(tp_index), 32'(m_pos));
        chk("busy", 32'(busy), 32'(m_active));
        chk("mct_done", 32'(mct_done), 32'(m_done));
        chk("mct_count", 32'(mct_count), 32'(exp_cnt));
        chk("onehot", 32'($countones(tp) <= 1), 32'd1);
    endtask

    task automatic tick(input logic r, input logic ru, input logic st,
                        input logic sm, input logic sp);
        rst       = r;
        run       = ru;
        stall     = st;
        step_mode = sm;
        step      = sp;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Free-run until the model reaches the given pulse; an expired budget counts as a failure.
    task automatic run_to(input int pos, input string tag);
        int budget;
        budget = 3 * NP;
        while (!(m_active && m_pos == pos) && budget > 0) begin
            tick(0, 1, 0, 0, 0);
            budget--;
        end
        chk(tag, 32'(budget > 0), 32'd1);
    endtask

    initial begin
        // Reset held with run=1.
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);

        // Free run: 30 clks, mct_done at clks 13 and 25.
        for (int i = 0; i < 30; i++) tick(0, 1, 0, 0, 0);

        // Stall for 3 clks on tp[4].
        run_to(4, "reach_idx4");
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 0);
        tick(0, 1, 0, 0, 0);
        chk("after_stall_idx", 32'(tp_index), 32'd5);

        // Drop run at tp[6]: MCT completes, then idle.
        run_to(6, "reach_idx6");
        for (int i = 0; i < NP; i++) tick(0, 0, 0, 0, 0);
        chk("stopped_busy", 32'(busy), 32'd0);

        // Step mode from idle, strobes 5 clks apart; a stalled step is dropped.
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 0, 1, 1);
            for (int i = 0; i < 4; i++) tick(0, 1, 0, 1, 0);
        end
        chk("step_idx", 32'(tp_index), 32'd2);
        tick(0, 1, 1, 1, 1);
        tick(0, 1, 0, 1, 0);
        chk("stalled_step_idx", 32'(tp_index), 32'd2);

        // Reset mid-MCT at tp[9].
        run_to(9, "reach_idx9");
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);

        // 17 back-to-back MCTs to wrap a 4-bit counter.
        for (int i = 0; i < 17 * NP + 1; i++) tick(0, 1, 0, 0, 0);

        // Randomized mix of all controls.
        for (int i = 0; i < 4000; i++) begin
            logic r, ru, st, sm, sp;
            r  = ($urandom_range(0, 199) == 0);
            ru = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 6) == 0);
            sm = (($urandom_range(0, 49) == 0) ? !step_mode : step_mode);
            sp = ($urandom_range(0, 2) == 0);
            tick(r, ru, st, sm, sp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
